// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master with a two-stage (address/data) pipeline; the response pulses one cycle after the data phase ends.
// cmd_ready drops while A is stalled by hready=0, hresp or an error hold; stalled data phases abort after TIMEOUT wait cycles.
module ahb_lite_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        n_rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,

    output logic        hsel,
    output logic [3:0]  haddr,
    output logic [1:0]  htrans,
    output logic [1:0]  hsize,
    output logic        hwrite,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [7:0] TO_LAST       = 8'(TIMEOUT - 1);

    // Address-phase stage
    logic        a_vld_q,   a_vld_d;
    logic        a_write_q, a_write_d;
    logic [3:0]  a_addr_q,  a_addr_d;
    logic [1:0]  a_size_q,  a_size_d;
    logic [31:0] a_wdata_q, a_wdata_d;

    // Data-phase stage
    logic        d_vld_q,   d_vld_d;
    logic        d_write_q, d_write_d;
    logic [31:0] hwdata_q,  hwdata_d;

    logic        err_hold_q, err_hold_d;
    logic [7:0]  to_cnt_q,   to_cnt_d;

    logic        rsp_vld_q,     rsp_vld_d;
    logic [31:0] rsp_rdata_q,   rsp_rdata_d;
    logic        rsp_error_q,   rsp_error_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic        adv;
    logic        d_done;
    logic        to_fire;
    logic        accept;
    logic        a_drive;

    assign a_drive   = a_vld_q && !err_hold_q;
    assign cmd_ready = !a_vld_q || (hready && !err_hold_q && !hresp);

    assign hsel   = a_drive;
    assign htrans = a_drive ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr  = a_drive ? a_addr_q  : 4'd0;
    assign hsize  = a_drive ? a_size_q  : 2'd0;
    assign hwrite = a_drive ? a_write_q : 1'b0;
    assign hburst = 3'b000;
    assign hwdata = hwdata_q;

    assign rsp_valid   = rsp_vld_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

    always_comb begin
        adv     = hready && !err_hold_q;
        d_done  = d_vld_q && hready;
        to_fire = d_vld_q && !hready && (to_cnt_q == TO_LAST);
        accept  = cmd_valid && cmd_ready;

        a_vld_d       = a_vld_q;
        a_write_d     = a_write_q;
        a_addr_d      = a_addr_q;
        a_size_d      = a_size_q;
        a_wdata_d     = a_wdata_q;
        d_vld_d       = d_vld_q;
        d_write_d     = d_write_q;
        hwdata_d      = hwdata_q;
        err_hold_d    = err_hold_q;
        to_cnt_d      = 8'd0;
        rsp_vld_d     = 1'b0;
        rsp_rdata_d   = 32'd0;
        rsp_error_d   = 1'b0;
        rsp_timeout_d = 1'b0;

        // A either takes a new command or empties as its content moves to D
        if (accept) begin
            a_vld_d   = 1'b1;
            a_write_d = cmd_write;
            a_addr_d  = cmd_addr;
            a_size_d  = cmd_size;
            a_wdata_d = cmd_wdata;
        end else if (adv) begin
            a_vld_d = 1'b0;
        end

        // An erroring D retires while err_hold blocks A, so D empties instead of refilling
        if (to_fire) begin
            d_vld_d  = 1'b0;
            hwdata_d = 32'd0;
        end else if (hready) begin
            if (adv) begin
                d_vld_d   = a_vld_q;
                d_write_d = a_write_q;
                hwdata_d  = (a_vld_q && a_write_q) ? a_wdata_q : 32'd0;
            end else begin
                d_vld_d  = 1'b0;
                hwdata_d = 32'd0;
            end
        end

        if (to_fire || d_done) begin
            err_hold_d = 1'b0;
        end else if (d_vld_q && hresp && !hready) begin
            err_hold_d = 1'b1;
        end

        if (d_vld_q && !hready && !to_fire) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end

        if (d_done) begin
            rsp_vld_d   = 1'b1;
            rsp_rdata_d = d_write_q ? 32'd0 : hrdata;
            rsp_error_d = hresp;
        end else if (to_fire) begin
            rsp_vld_d     = 1'b1;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_vld_q       <= 1'b0;
            a_write_q     <= 1'b0;
            a_addr_q      <= 4'd0;
            a_size_q      <= 2'd0;
            a_wdata_q     <= 32'd0;
            d_vld_q       <= 1'b0;
            d_write_q     <= 1'b0;
            hwdata_q      <= 32'd0;
            err_hold_q    <= 1'b0;
            to_cnt_q      <= 8'd0;
            rsp_vld_q     <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            a_vld_q       <= a_vld_d;
            a_write_q     <= a_write_d;
            a_addr_q      <= a_addr_d;
            a_size_q      <= a_size_d;
            a_wdata_q     <= a_wdata_d;
            d_vld_q       <= d_vld_d;
            d_write_q     <= d_write_d;
            hwdata_q      <= hwdata_d;
            err_hold_q    <= err_hold_d;
            to_cnt_q      <= to_cnt_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: slave responses driven per cycle, outputs sampled on the falling edge.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        hsel;
    logic [3:0]  haddr;
    logic [1:0]  htrans;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_chk  = 0;
    int n_pass = 0;

    ahb_lite_master #(.TIMEOUT(16)) dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
        .hwrite(hwrite), .hburst(hburst), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic offer(input logic wr, input logic [3:0] addr, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_size  = 2'd2;
        cmd_wdata = wd;
    endtask

    int seen_rsp;

    initial begin
        n_rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0;
        cmd_size = 2'd0; cmd_wdata = 32'd0; hrdata = 32'd0; hready = 1'b1; hresp = 1'b0;
        smp();
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_hsel", {31'd0, hsel}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_hburst", {29'd0, hburst}, 32'd0);
        nxt(); n_rst = 1'b1;

        // single write
        nxt(); offer(1'b1, 4'd0, 32'hDEADBEEF);
        smp(); chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        nxt(); cmd_valid = 1'b0;
        smp(); chk("wr_htrans", {30'd0, htrans}, 32'd2);
        chk("wr_haddr", {28'd0, haddr}, 32'd0);
        chk("wr_hwrite", {31'd0, hwrite}, 32'd1);
        chk("wr_hsize", {30'd0, hsize}, 32'd2);
        nxt(); smp();
        chk("wr_hwdata", hwdata, 32'hDEADBEEF);
        chk("wr_idle_after", {30'd0, htrans}, 32'd0);
        chk("wr_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
        nxt(); smp();
        chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        nxt(); smp();
        chk("wr_rsp_oneshot", {31'd0, rsp_valid}, 32'd0);

        // single read
        nxt(); offer(1'b0, 4'd8, 32'd0);
        nxt(); cmd_valid = 1'b0;
        smp(); chk("rd_haddr", {28'd0, haddr}, 32'd8);
        chk("rd_hwrite", {31'd0, hwrite}, 32'd0);
        nxt(); hrdata = 32'h00000040;
        nxt(); hrdata = 32'd0;
        smp(); chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h00000040);
        chk("rd_rsp_error", {31'd0, rsp_error}, 32'd0);

        // back-to-back write then read
        nxt(); offer(1'b1, 4'd0, 32'h11223344);
        nxt(); offer(1'b0, 4'd12, 32'd0);
        smp(); chk("b2b_accept2", {31'd0, cmd_ready}, 32'd1);
        nxt(); cmd_valid = 1'b0;
        smp(); chk("b2b_rd_addr", {28'd0, haddr}, 32'd12);
        chk("b2b_rd_nonseq", {30'd0, htrans}, 32'd2);
        chk("b2b_wr_data_overlap", hwdata, 32'h11223344);
        nxt(); hrdata = 32'hCAFE0012;
        smp(); chk("b2b_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rsp1_rdata", rsp_rdata, 32'd0);
        nxt(); hrdata = 32'd0;
        smp(); chk("b2b_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rsp2_rdata", rsp_rdata, 32'hCAFE0012);
        nxt(); smp();
        chk("b2b_rsp_end", {31'd0, rsp_valid}, 32'd0);

        // two-cycle error response with a read waiting in A
        nxt(); offer(1'b1, 4'd5, 32'h00000055);
        nxt(); offer(1'b0, 4'd3, 32'd0);
        smp(); chk("err_wr_haddr", {28'd0, haddr}, 32'd5);
        nxt(); cmd_valid = 1'b0; hready = 1'b0; hresp = 1'b1;
        smp(); chk("err1_htrans", {30'd0, htrans}, 32'd2);
        chk("err1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        nxt(); hready = 1'b1; hresp = 1'b1;
        smp(); chk("err2_htrans_idle", {30'd0, htrans}, 32'd0);
        chk("err2_hsel", {31'd0, hsel}, 32'd0);
        nxt(); hresp = 1'b0;
        smp(); chk("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("err_rsp_error", {31'd0, rsp_error}, 32'd1);
        chk("err_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("err_reissue_htrans", {30'd0, htrans}, 32'd2);
        chk("err_reissue_haddr", {28'd0, haddr}, 32'd3);
        nxt(); hrdata = 32'h00000033;
        smp(); chk("err_no_rsp", {31'd0, rsp_valid}, 32'd0);
        nxt(); hrdata = 32'd0;
        smp(); chk("reissue_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("reissue_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("reissue_rsp_rdata", rsp_rdata, 32'h00000033);

        // timeout: 16 wait cycles in the data phase
        nxt(); offer(1'b0, 4'd1, 32'd0);
        nxt(); cmd_valid = 1'b0;
        nxt(); hready = 1'b0; hrdata = 32'hFFFFFFFF;
        seen_rsp = 0;
        smp(); if (rsp_valid) seen_rsp++;
        for (int i = 1; i < 16; i++) begin
            nxt(); smp();
            if (rsp_valid) seen_rsp++;
        end
        chk("to_no_early_rsp", seen_rsp, 32'd0);
        nxt(); smp();
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_error", {31'd0, rsp_error}, 32'd1);
        chk("to_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        nxt(); hready = 1'b1; hrdata = 32'd0;
        smp(); chk("to_rsp_oneshot", {31'd0, rsp_valid}, 32'd0);
        chk("to_flag_clear", {31'd0, rsp_timeout}, 32'd0);

        // reset in the middle of a stalled transfer
        nxt(); offer(1'b1, 4'd7, 32'h00000077);
        nxt(); offer(1'b0, 4'd9, 32'd0);
        nxt(); cmd_valid = 1'b0; hready = 1'b0;
        smp(); chk("mid_htrans", {30'd0, htrans}, 32'd2);
        chk("mid_hwdata", hwdata, 32'h00000077);
        #1 n_rst = 1'b0;
        #1;
        chk("arst_htrans", {30'd0, htrans}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_hwdata", hwdata, 32'd0);
        nxt(); hready = 1'b1; n_rst = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (rsp_valid) seen_rsp++;
            nxt();
        end
        chk("arst_no_rsp", seen_rsp, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of consecutive data-phase wait cycles before abort (range 2-255).
REQ-002 SHALL have clk  input  1  rising-edge system clock.
REQ-003 SHALL have n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have cmd_valid  input  1  command offered.
REQ-005 SHALL have cmd_ready  output  1  command accepted on this edge if cmd_valid.
REQ-006 SHALL have cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have cmd_addr  input  4  target register address.
REQ-008 SHALL have cmd_size  input  2  0=byte, 1=half, 2=word.
REQ-009 SHALL have cmd_wdata  input  32  write data.
REQ-010 SHALL have rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have rsp_rdata  output  32  read data (0 for writes).
REQ-012 SHALL have rsp_error  output  1  transfer ended with hresp or timeout.
REQ-013 SHALL have rsp_timeout  output  1  transfer aborted by timeout.
REQ-014 SHALL have hsel, haddr[3:0], htrans[1:0], hsize[1:0], hwrite, hburst[2:0], hwdata[31:0] as outputs, and hrdata[31:0], hready, hresp as inputs, with AHB-Lite meaning.

Function
REQ-015 SHALL implement a two-stage pipeline: A (address phase) and D (data phase), each with a valid bit.
REQ-016 SHALL drive hburst=3'b000 constantly; htrans is only IDLE (2'd0) or NONSEQ (2'd2).
REQ-017 SHALL drive hsel=1, htrans=NONSEQ, and haddr/hsize/hwrite from A while A is valid and err_hold=0; otherwise hsel=0, htrans=IDLE, haddr/hsize/hwrite=0.
REQ-018 SHALL assert cmd_ready = !A_valid || (hready && !err_hold && !hresp).
REQ-019 SHALL load A from cmd_* on an edge where cmd_valid && cmd_ready, so that the command drives the bus in the next cycle.
REQ-020 SHALL, on an edge with hready=1 and err_hold=0, move A to D (D_valid<=A_valid) and latch the A write data onto hwdata for the entire data phase.
REQ-021 SHALL hold A and D unchanged on an edge with hready=0.
REQ-022 SHALL, when D completes (edge with D_valid && hready=1), pulse rsp_valid for one cycle in the following cycle; rsp_rdata = hrdata for a read or 0 for a write; rsp_error = hresp; rsp_timeout = 0.
REQ-023 SHALL set err_hold at an edge with D_valid && hresp=1 && hready=0 (first error cycle), forcing htrans=IDLE next cycle while A is retained, not advanced.
REQ-024 SHALL clear err_hold on the edge where the erroring D completes; a retained A command SHALL then be re-presented as NONSEQ in the next cycle.
REQ-025 SHALL count consecutive cycles with D_valid && hready=0 (8-bit counter, cleared on any hready=1 or !D_valid).
REQ-026 SHALL, when the count reaches TIMEOUT, drop D, clear err_hold, and pulse rsp_valid with rsp_error=1, rsp_timeout=1, rsp_rdata=0; A is kept.
REQ-027 SHALL, on simultaneous completion and acceptance, emit the response, advance A to D, and load the new command into A on the same edge.
REQ-028 SHALL hold rsp_rdata/rsp_error/rsp_timeout at 0 whenever rsp_valid=0.

Reset
REQ-029 SHALL, with n_rst=0, immediately clear A_valid, D_valid, err_hold, the timeout counter, and all registered outputs; hsel=0, htrans=0, haddr=0, hsize=0, hwrite=0, hwdata=0, rsp_*=0, cmd_ready=1.
REQ-030 SHALL discard any in-flight transfer on reset assertion with no response produced.

Verification
REQ-031 SHALL verify: write addr 0, size 2, data 0xDEADBEEF, hready=1 -> NONSEQ at cycle+1, hwdata=0xDEADBEEF at cycle+2, rsp_valid at cycle+3, rsp_error=0.
REQ-032 SHALL verify: read addr 8 with hrdata=0x00000040 -> rsp_rdata=0x00000040, rsp_error=0.
REQ-033 SHALL verify: back-to-back write 0 then read 12 -> address of the read overlaps the write data phase; two rsp_valid pulses on consecutive cycles.
REQ-034 SHALL verify: write addr 5 with slave hresp=1/hready=0 then hresp=1/hready=1, read pending in A -> htrans=IDLE in the second error cycle, rsp_error=1, then the read is reissued and completes with rsp_error=0.
REQ-035 SHALL verify: hready held 0 for 16 cycles in the data phase -> rsp_valid with rsp_error=1 and rsp_timeout=1 at cycle 16.
REQ-036 SHALL verify: n_rst pulled low mid-transfer -> htrans=0 and cmd_ready=1 at once, and no rsp_valid after release.
